ped_crossing_ctrl: RTL and testbench

- Pedestrian signal stage directly downstream of the vehicle traffic-light controller.
- Consumes the controller's red/yellow/green outputs and a 1 Hz tick.
- Debounces a pedestrian push-button and drives WALK / flashing DON'T-WALK lamps inside the vehicle red phase.
- Flags a sticky fault if vehicle red drops during a crossing or the light inputs are not one-hot.

---
 rtl/ped_crossing_ctrl_pkg.sv | 30 +++
 rtl/ped_crossing_ctrl_if.sv | 24 ++
 rtl/ped_crossing_ctrl_debouncer.sv | 57 +++++
 rtl/ped_crossing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing stage: state encoding,
// default timing constants and the vehicle-lamp one-hot check.
package ped_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RED = 2'd1,
      WALK     = 2'd2,
      FLASH    = 2'd3
   } ped_state_t;

   localparam int DEF_WALK_SECS       = 5;
   localparam int DEF_FLASH_SECS      = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_CNT_W           = 4;

   // True when exactly one of the three vehicle lamps is lit.
   function automatic logic lights_onehot(input logic red, input logic yellow,
                                          input logic green);
      logic ok;
      case ({red, yellow, green})
         3'b100:  ok = 1'b1;
         3'b010:  ok = 1'b1;
         3'b001:  ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ped_crossing_ctrl_if.sv
// Signal bundle between the vehicle controller side and the pedestrian stage.
// The master drives lamps, tick and the raw button; the slave (the pedestrian
// stage) drives the pedestrian lamps, request and fault flags.
interface ped_crossing_ctrl_if;
   logic tick;
   logic veh_red;
   logic veh_yellow;
   logic veh_green;
   logic ped_button;
   logic walk;
   logic dont_walk;
   logic ped_req;
   logic fault;

   modport master (
      output tick, veh_red, veh_yellow, veh_green, ped_button,
      input  walk, dont_walk, ped_req, fault
   );

   modport slave (
      input  tick, veh_red, veh_yellow, veh_green, ped_button,
      output walk, dont_walk, ped_req, fault
   );
endinterface

// File: rtl/ped_crossing_ctrl_debouncer.sv
// Push-button conditioning: two-flop synchroniser, debounce counter that
// accepts a new level only after it has been stable for DEBOUNCE_CYCLES
// cycles, and a one-cycle press pulse on the accepted rising edge.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic press
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          debounced_r;
   logic [DW-1:0] deb_cnt_r;
   logic          press_r;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= button;
         sync2_r <= sync1_r;
      end
   end

   // Count consecutive cycles of disagreement; a bounce restarts the count.
   // The press pulse is raised in the same edge that debounced goes high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         debounced_r <= 1'b0;
         deb_cnt_r   <= {DW{1'b0}};
         press_r     <= 1'b0;
      end else if (sync2_r != debounced_r) begin
         if (deb_cnt_r == CNT_LAST) begin
            debounced_r <= sync2_r;
            deb_cnt_r   <= {DW{1'b0}};
            press_r     <= sync2_r;
         end else begin
            deb_cnt_r   <= deb_cnt_r + DW'(1);
            press_r     <= 1'b0;
         end
      end else begin
         deb_cnt_r <= {DW{1'b0}};
         press_r   <= 1'b0;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal stage. Latches debounced button presses, waits for a
// fresh vehicle red onset, then runs steady WALK followed by flashing
// DON'T-WALK, all counted in 1 Hz ticks. Loss of vehicle red during a
// crossing, or non-one-hot vehicle lamps, raise a fault that holds the
// crossing in DON'T-WALK until reset.
module ped_crossing_ctrl
   import ped_pkg::*;
#(
   parameter int WALK_SECS       = DEF_WALK_SECS,
   parameter int FLASH_SECS      = DEF_FLASH_SECS,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   ped_crossing_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_SECS - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_SECS - 1);

   ped_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             flash_phase_r;
   logic             veh_red_d_r;
   logic             walk_r;
   logic             dont_walk_r;
   logic             ped_req_r;
   logic             fault_r;

   logic             press_s;
   logic             red_start_s;
   logic             lights_bad_s;
   logic             in_crossing_s;
   logic             abort_s;
   logic             enter_walk_s;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk    (clk),
      .reset  (reset),
      .button (bus.ped_button),
      .press  (press_s)
   );

   // Decode red onset, lamp sanity, abort and the WAIT_RED -> WALK hand-off.
   always_comb begin
      lights_bad_s  = ~lights_onehot(bus.veh_red, bus.veh_yellow, bus.veh_green);
      red_start_s   = bus.veh_red & ~veh_red_d_r;
      in_crossing_s = (state_r == WALK) | (state_r == FLASH);
      abort_s       = lights_bad_s | (in_crossing_s & ~bus.veh_red);
      enter_walk_s  = (state_r == WAIT_RED) & red_start_s & ~abort_s;
   end

   // Remember last red level; resets high so a request waits for a new onset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         veh_red_d_r <= 1'b1;
      end else begin
         veh_red_d_r <= bus.veh_red;
      end
   end

   // Request latch: a press always sets it, even in the cycle WALK starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ped_req_r <= 1'b0;
      end else if (press_s) begin
         ped_req_r <= 1'b1;
      end else if (enter_walk_s) begin
         ped_req_r <= 1'b0;
      end else begin
         ped_req_r <= ped_req_r;
      end
   end

   // Crossing sequencer with registered lamp outputs and sticky fault.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         flash_phase_r <= 1'b0;
         walk_r        <= 1'b0;
         dont_walk_r   <= 1'b1;
         fault_r       <= 1'b0;
      end else if (abort_s) begin
         fault_r       <= 1'b1;
         state_r       <= IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         flash_phase_r <= 1'b0;
         walk_r        <= 1'b0;
         dont_walk_r   <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               walk_r      <= 1'b0;
               dont_walk_r <= 1'b1;
               if (ped_req_r && !fault_r) begin
                  state_r <= WAIT_RED;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT_RED: begin
               if (red_start_s) begin
                  state_r     <= WALK;
                  cnt_r       <= {CNT_W{1'b0}};
                  walk_r      <= 1'b1;
                  dont_walk_r <= 1'b0;
               end else begin
                  state_r <= WAIT_RED;
               end
            end
            WALK: begin
               if (bus.tick) begin
                  if (cnt_r == WALK_LAST) begin
                     state_r       <= FLASH;
                     cnt_r         <= {CNT_W{1'b0}};
                     flash_phase_r <= 1'b1;
                     walk_r        <= 1'b0;
                     dont_walk_r   <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end else begin
                  state_r <= WALK;
               end
            end
            FLASH: begin
               if (bus.tick) begin
                  if (cnt_r == FLASH_LAST) begin
                     state_r       <= IDLE;
                     cnt_r         <= {CNT_W{1'b0}};
                     flash_phase_r <= 1'b0;
                     dont_walk_r   <= 1'b1;
                  end else begin
                     cnt_r         <= cnt_r + CNT_W'(1);
                     flash_phase_r <= ~flash_phase_r;
                     dont_walk_r   <= ~flash_phase_r;
                  end
               end else begin
                  state_r <= FLASH;
               end
            end
            default: begin
               state_r       <= IDLE;
               cnt_r         <= {CNT_W{1'b0}};
               flash_phase_r <= 1'b0;
               walk_r        <= 1'b0;
               dont_walk_r   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.walk      = walk_r;
   assign bus.dont_walk = dont_walk_r;
   assign bus.ped_req   = ped_req_r;
   assign bus.fault     = fault_r;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed stimulus, a tick-level model of the
// crossing rules compared every cycle, and hand-computed literal checks.
module tb_ped_crossing_ctrl;

   localparam int W  = 5;
   localparam int F  = 4;
   localparam int D  = 4;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   chk_en = 1'b0;
   bit   cap_en = 1'b0;
   int   cap_w[$];
   int   cap_d[$];

   // model state: 0 idle, 1 waiting for red onset, 2 crossing
   logic m_q[$];
   logic m_deb, m_press_prev, m_req, m_fault, m_red_prev;
   int   m_mode, m_el, m_presses;

   ped_crossing_ctrl_if bus();

   ped_crossing_ctrl #(
      .WALK_SECS(W), .FLASH_SECS(F), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // advance to the next falling edge and drive the 1 Hz tick (every 10 clks)
   task automatic step();
      @(negedge clk);
      cyc++;
      bus.tick = ((cyc % 10) == 0);
   endtask

   task automatic m_init();
      m_q.delete();
      for (int i = 0; i < D + 2; i++) m_q.push_back(1'b0);
      m_deb = 1'b0; m_press_prev = 1'b0; m_req = 1'b0; m_fault = 1'b0;
      m_red_prev = 1'b1; m_mode = 0; m_el = 0;
   endtask

   task automatic m_step();
      logic r, y, g, tk;
      bit bad_l, abort_l, onset_l, all_diff, press_now, req_old;
      r = bus.veh_red; y = bus.veh_yellow; g = bus.veh_green; tk = bus.tick;
      // button: level accepted once pin samples t-2 .. t-1-D all differ
      m_q.push_front(bus.ped_button);
      void'(m_q.pop_back());
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (m_q[k] == m_deb) all_diff = 1'b0;
      press_now = 1'b0;
      if (all_diff) begin
         m_deb = ~m_deb;
         press_now = m_deb;
         if (press_now) m_presses++;
      end
      bad_l   = (2'(r) + 2'(y) + 2'(g)) != 2'd1;
      abort_l = bad_l || (m_mode == 2 && !r);
      onset_l = r && !m_red_prev;
      req_old = m_req;
      if (m_press_prev) m_req = 1'b1;
      else if (m_mode == 1 && onset_l && !abort_l) m_req = 1'b0;
      if (abort_l) begin
         m_fault = 1'b1; m_mode = 0; m_el = 0;
      end else if (m_mode == 0) begin
         if (req_old && !m_fault) m_mode = 1;
      end else if (m_mode == 1) begin
         if (onset_l) begin m_mode = 2; m_el = 0; end
      end else if (tk) begin
         m_el++;
         if (m_el == W + F) begin m_mode = 0; m_el = 0; end
      end
      m_red_prev   = r;
      m_press_prev = press_now;
   endtask

   initial begin
      m_presses = 0;
      m_init();
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_init();
         else m_step();
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("walk", int'(bus.walk), int'(m_mode == 2 && m_el < W));
         check("dont_walk", int'(bus.dont_walk),
               int'(m_mode != 2 || (m_el >= W && ((m_el - W) % 2) == 0)));
         check("ped_req", int'(bus.ped_req), int'(m_req));
         check("fault", int'(bus.fault), int'(m_fault));
         check("lamps_exclusive", int'(bus.walk & bus.dont_walk), 0);
      end
   end

   // lamp values seen on each tick while capturing
   always @(posedge clk) begin
      if (cap_en && bus.tick) begin
         cap_w.push_back(int'(bus.walk));
         cap_d.push_back(int'(bus.dont_walk));
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_walk"}, int'(bus.walk), 0);
      check({tag, "_dont_walk"}, int'(bus.dont_walk), 1);
      check({tag, "_ped_req"}, int'(bus.ped_req), 0);
      check({tag, "_fault"}, int'(bus.fault), 0);
   endtask

   task automatic press_hold();
      bus.ped_button = 1'b1;
      repeat (10) step();
      bus.ped_button = 1'b0;
      repeat (10) step();
   endtask

   task automatic go_red();
      bus.veh_green = 1'b0; bus.veh_yellow = 1'b1;
      repeat (3) step();
      bus.veh_yellow = 1'b0; bus.veh_red = 1'b1;
   endtask

   task automatic go_green();
      bus.veh_red = 1'b0; bus.veh_green = 1'b1;
   endtask

   task automatic pulse_reset(input string tag);
      step();
      #2 reset = 1'b1;
      #1 check_reset_vals(tag);
      step();
      reset = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      int exp_w[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
      int exp_d[9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
      int n;
      bus.tick = 1'b0; bus.veh_red = 1'b0; bus.veh_yellow = 1'b0;
      bus.veh_green = 1'b1; bus.ped_button = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_vals("reset");
      repeat (3) step();
      reset = 1'b0;
      chk_en = 1'b1;
      repeat (5) step();

      // glitches then a stable press during green
      for (int i = 0; i < 3; i++) begin
         bus.ped_button = 1'b1; step();
         bus.ped_button = 1'b0; step();
      end
      repeat (6) step();
      bus.ped_button = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (k == 6) check("req_before_latency", int'(bus.ped_req), 0);
         if (k == 7) check("req_latency", int'(bus.ped_req), 1);
      end
      repeat (3) step();
      bus.ped_button = 1'b0;
      repeat (10) step();
      check("model_single_press", m_presses, 1);
      check("req_held_green", int'(bus.ped_req), 1);

      // full crossing on the next red
      go_red();
      step();
      check("walk_after_onset", int'(bus.walk), 1);
      check("req_cleared_walk", int'(bus.ped_req), 0);
      cap_en = 1'b1;
      n = 0;
      while (cap_w.size() < 9 && n < 200) begin step(); n++; end
      cap_en = 1'b0;
      if (cap_w.size() == 9) begin
         for (int i = 0; i < 9; i++) begin
            check($sformatf("tick%0d_walk", i + 1), cap_w[i], exp_w[i]);
            check($sformatf("tick%0d_dont_walk", i + 1), cap_d[i], exp_d[i]);
         end
      end else begin
         check("crossing_tick_timeout", cap_w.size(), 9);
      end
      check("end_walk", int'(bus.walk), 0);
      check("end_dont_walk", int'(bus.dont_walk), 1);
      check("end_ped_req", int'(bus.ped_req), 0);
      repeat (5) step();
      go_green();
      repeat (20) step();

      // request placed mid-red waits for the next onset
      go_red();
      repeat (15) step();
      press_hold();
      repeat (20) step();
      check("no_walk_midred", int'(bus.walk), 0);
      check("req_pending_midred", int'(bus.ped_req), 1);
      go_green();
      repeat (20) step();
      go_red();
      check("walk_before_onset", int'(bus.walk), 0);
      step();
      check("walk_next_onset", int'(bus.walk), 1);
      repeat (110) step();
      check("second_end_walk", int'(bus.walk), 0);
      go_green();
      repeat (10) step();

      // red drops on the third WALK tick
      press_hold();
      go_red();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (bus.tick) n++;
         if (n == 3) break;
      end
      check("abort_tick_found", n, 3);
      check("walk_before_abort", int'(bus.walk), 1);
      go_green();
      step();
      check("abort_walk", int'(bus.walk), 0);
      check("abort_dont_walk", int'(bus.dont_walk), 1);
      check("abort_fault", int'(bus.fault), 1);
      repeat (5) step();
      press_hold();
      check("faulted_req", int'(bus.ped_req), 1);
      go_red();
      repeat (5) step();
      check("faulted_no_walk", int'(bus.walk), 0);
      check("faulted_sticky", int'(bus.fault), 1);
      go_green();
      pulse_reset("reset_after_abort");

      // illegal lamps for one cycle while idle
      repeat (5) step();
      bus.veh_red = 1'b1;
      step();
      bus.veh_red = 1'b0;
      step();
      check("illegal_fault", int'(bus.fault), 1);
      repeat (20) step();
      check("illegal_fault_sticky", int'(bus.fault), 1);
      pulse_reset("reset_after_illegal");

      // asynchronous reset in the middle of FLASH
      press_hold();
      go_red();
      n = 0;
      for (int i = 0; i < 120; i++) begin
         step();
         if (bus.tick) n++;
         if (n == 6) break;
      end
      repeat (3) step();
      check("flash_low_phase", int'(bus.dont_walk), 0);
      check("flash_walk_off", int'(bus.walk), 0);
      #2 reset = 1'b1;
      #1 check_reset_vals("reset_mid_flash");
      step();
      go_green();
      reset = 1'b0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
